onchipalarm_mode_ctrl: RTL and testbench
========================================

# onchipAlarm_mode_ctrl

Debounced mode-button controller for the alarm clock SoC. Synchronizes and debounces the raw front-panel mode button. Sequences the clock's operating mode (show time, set hour, set minute, set alarm hour, set alarm minute) on each accepted press. Exposes debounced level, current mode, press capture and interrupt to the Nios II over a 4-word Avalon-MM slave with read latency 1.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new button level (10 ms at 50 MHz); legal ≥ 1
- NUM_MODES, 5, number of modes in the sequence; legal 2..8
- clk  in  1  system clock
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_port  in  1  raw mode button, active-high, asynchronous to clk
- address  in  2  Avalon word address
- chipselect  in  1  Avalon slave select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, registered
- mode  out  3  current mode index, direct to display/time-set logic
- irq  out  1  press interrupt, active-high, level

## Operation
- Synchronizer: 2-FF chain on in_port → `btn_s`.
- Debouncer:
  - Holds debounced level `btn_d`.
  - Counter clears whenever `btn_s == btn_d`, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES−1 with `btn_s != btn_d`, then `btn_d <= btn_s` and the counter clears.
  - Any bounce before that point restarts the count.
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- Press: 0→1 transition of `btn_d`, a single-cycle `press` pulse. Release, 1→0, produces no action.
- Mode sequencer:
  - On `press`, mode ← mode+1, wrapping NUM_MODES−1 → 0.
  - Software write to address 1: mode ← writedata[2:0] if the value is < NUM_MODES; out-of-range writes are ignored.
  - Write and press in the same cycle: the write wins and the press does not advance mode.
  - Edge capture is still set in that case.
- Register map (write = chipselect & ~write_n):
  - 0: read {31'b0, btn_d}; writes ignored.
  - 1: read {29'b0, mode}; write sets mode as above.
  - 2: edgecapture, read {31'b0, ec}. `press` sets ec. Write with writedata[0]=1 clears ec. Simultaneous press and clear leaves ec=1.
  - 3: irqmask, read {31'b0, msk}; write msk ← writedata[0].
- readdata is updated every clock from the address mux, independent of chipselect.

## Timing
- Reset values: readdata=0, mode=0, irq=0, btn_d=0, ec=0, msk=0, synchronizer=0, counter=0.
- Reset mid-debounce discards the count. A button held through reset release is accepted DEBOUNCE_CYCLES cycles after `btn_s` goes high.
- Latency from a clean in_port rise, sampled at edge E0:
  - `btn_s` = 1 after E1.
  - `btn_d` = 1 after E1+DEBOUNCE_CYCLES.
  - `press` is high for the following cycle.
  - mode and ec update on edge E2+DEBOUNCE_CYCLES.
- Read latency: 1 cycle after address is presented. Write takes effect on the same edge it is sampled.
- mode output is driven directly from the register, no added latency.

## Configuration
- Macro: `ONCHIPALARM_MODE_IRQ_EN`.
- Defined: the msk register exists; irq = ec & msk, registered, asserting 1 cycle after ec sets while msk=1. irq stays high until ec is cleared or msk is cleared.
- Undefined: no msk register; address 3 reads 0 and writes are ignored; irq is tied to 0. ec still operates for polling.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, NUM_MODES=5.
- Reset state: assert reset_n=0 mid-run, then read addresses 0-3 → all readdata=0, mode=0, irq=0.
- Clean press: hold in_port=1 for 20 cycles → mode 0→1 exactly 6 cycles after the first high sample; ec=1; a single increment only.
- Bounce rejection: toggle in_port 1,1,1,0,1,1,1,0 repeatedly → mode unchanged, btn_d=0. Then hold 1 for 5 cycles → one increment.
- Wrap-around: 5 clean presses from mode=3 → sequence 4,0,1,2,3. Write 7 to address 1 → mode stays 3. Write 2 → mode=2 the next cycle.
- Collisions:
  - Write mode=0 on the same edge as `press` → mode=0 and ec=1.
  - Write 1 to address 2 on the same edge as `press` → ec remains 1.
- IRQ, macro defined: msk=1, press → irq=1 one cycle after ec; clear ec → irq=0 next cycle.
- IRQ, macro undefined: a press leaves irq=0, and address 3 reads 0.

Source files
------------

// File: rtl/onchipalarm_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : onchipalarm_mode_ctrl
// Purpose  : Debounced mode-button controller. Synchronizes and debounces the
//            raw front-panel button, steps the operating mode on each accepted
//            press, and exposes level/mode/edge-capture/irq-mask through a
//            4-word Avalon-MM slave with read latency 1.
// Ports    : clk, reset_n (async, active-low)
//            in_port     raw button, asynchronous to clk
//            address/chipselect/write_n/writedata  Avalon slave inputs
//            readdata    registered Avalon read data
//            mode        current mode index
//            irq         level interrupt (ec & msk, registered)
// Config   : define ONCHIPALARM_MODE_IRQ_EN to build the irq-mask register
//            and drive irq; otherwise address 3 reads 0 and irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module onchipalarm_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_MODES       = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_port,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [2:0]  mode,
  output logic        irq
);

  localparam int                 c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]         c_MODE_LAST = 3'(NUM_MODES - 1);
  localparam logic [3:0]         c_NUM_MODES = 4'(NUM_MODES);

  logic               r_sync_meta;
  logic               r_btn_s;
  logic               r_btn_d;
  logic               r_btn_d_q;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_mode;
  logic               r_ec;
  logic               r_msk;
  logic               r_irq;
  logic [31:0]        r_readdata;

  logic               w_press;
  logic               w_wr;
  logic               w_mode_wr;
  logic               w_ec_clr;
  logic [31:0]        w_rdata;
  logic               w_unused;

  // Only the low data bits are architecturally meaningful.
  assign w_unused = ^writedata[31:3];

  assign w_wr      = chipselect & ~write_n;
  assign w_mode_wr = w_wr && (address == 2'd1) && ({1'b0, writedata[2:0]} < c_NUM_MODES);
  assign w_ec_clr  = w_wr && (address == 2'd2) && writedata[0];
  assign w_press   = r_btn_d & ~r_btn_d_q;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b0;
      r_btn_s     <= 1'b0;
    end else begin
      r_sync_meta <= in_port;
      r_btn_s     <= r_sync_meta;
    end
  end

  // Debouncer: the level must disagree with btn_d for DEBOUNCE_CYCLES
  // consecutive cycles before it is accepted; any agreement restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_btn_d   <= 1'b0;
      r_btn_d_q <= 1'b0;
    end else begin
      r_btn_d_q <= r_btn_d;
      if (r_btn_s == r_btn_d) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_btn_d <= r_btn_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Mode sequencer: a valid software write takes priority over a press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= 3'd0;
    end else if (w_mode_wr) begin
      r_mode <= writedata[2:0];
    end else if (w_press) begin
      r_mode <= (r_mode == c_MODE_LAST) ? 3'd0 : r_mode + 3'd1;
    end
  end

  // Edge capture: a press in the same cycle as a clear keeps ec set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ec <= 1'b0;
    end else if (w_press) begin
      r_ec <= 1'b1;
    end else if (w_ec_clr) begin
      r_ec <= 1'b0;
    end
  end

`ifdef ONCHIPALARM_MODE_IRQ_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_msk <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && (address == 2'd3)) begin
        r_msk <= writedata[0];
      end
      r_irq <= r_ec & r_msk;
    end
  end
`else
  assign r_msk = 1'b0;
  assign r_irq = 1'b0;
`endif

  always_comb begin
    w_rdata = 32'd0;
    case (address)
      2'd0:    w_rdata = {31'd0, r_btn_d};
      2'd1:    w_rdata = {29'd0, r_mode};
      2'd2:    w_rdata = {31'd0, r_ec};
      default: w_rdata = {31'd0, r_msk};
    endcase
  end

  // Read data follows the address every clock, regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign mode     = r_mode;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_onchipalarm_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_onchipalarm_mode_ctrl
// Purpose  : Directed self-checking bench for onchipalarm_mode_ctrl with
//            DEBOUNCE_CYCLES=4, NUM_MODES=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onchipalarm_mode_ctrl;

  logic        clk;
  logic        reset_n;
  logic        in_port;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [2:0]  mode;
  logic        irq;

  int n_pass;
  int n_total;
  int n_fail;

  onchipalarm_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .NUM_MODES      (5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_port   (in_port),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .mode      (mode),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Clean press: mode is updated on the 7th edge after in_port goes high.
  task automatic do_press(input logic [2:0] exp_mode, input string tag);
    in_port = 1'b1;
    repeat (7) tick();
    check(tag, {29'd0, mode}, {29'd0, exp_mode});
    repeat (3) tick();
    in_port = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    reset_n = 1'b0; in_port = 1'b0; address = 2'd0;
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("init_mode", {29'd0, mode}, 32'd0);
    check("init_irq", {31'd0, irq}, 32'd0);

    // Clean press with exact latency.
    in_port = 1'b1;
    repeat (6) tick();
    check("press_lat_before", {29'd0, mode}, 32'd0);
    tick();
    check("press_lat_at", {29'd0, mode}, 32'd1);
    repeat (13) tick();
    check("press_single", {29'd0, mode}, 32'd1);
    in_port = 1'b0;
    repeat (10) tick();
    rd(2'd2, 32'd1, "press_ec");
    rd(2'd0, 32'd0, "release_btn_d");
    check("release_no_action", {29'd0, mode}, 32'd1);

    // Bounce rejection: runs of three highs never reach the threshold.
    for (int r = 0; r < 4; r++) begin
      in_port = 1'b1; repeat (3) tick();
      in_port = 1'b0; tick();
    end
    repeat (6) tick();
    check("bounce_mode", {29'd0, mode}, 32'd1);
    rd(2'd0, 32'd0, "bounce_btn_d");
    in_port = 1'b1; repeat (5) tick();
    in_port = 1'b0; repeat (10) tick();
    check("bounce_then_hold", {29'd0, mode}, 32'd2);

    // Reset mid-run.
    reset_n = 1'b0;
    #1;
    check("rst_mode", {29'd0, mode}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    rd(2'd0, 32'd0, "rst_rd0");
    rd(2'd1, 32'd0, "rst_rd1");
    rd(2'd2, 32'd0, "rst_rd2");
    rd(2'd3, 32'd0, "rst_rd3");

    // Wrap-around and software writes.
    wr(2'd1, 32'd3);
    check("wr_mode3", {29'd0, mode}, 32'd3);
    do_press(3'd4, "wrap_4");
    do_press(3'd0, "wrap_0");
    do_press(3'd1, "wrap_1");
    do_press(3'd2, "wrap_2");
    do_press(3'd3, "wrap_3");
    wr(2'd1, 32'd7);
    check("wr_out_of_range", {29'd0, mode}, 32'd3);
    wr(2'd1, 32'd2);
    check("wr_mode2", {29'd0, mode}, 32'd2);
    rd(2'd1, 32'd2, "rd_mode2");

    // Collision: mode write on the press edge wins, ec still sets.
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd0, "ec_cleared");
    in_port = 1'b1;
    repeat (6) tick();
    address = 2'd1; writedata = 32'd0; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    check("coll_mode_write_wins", {29'd0, mode}, 32'd0);
    repeat (2) tick();
    in_port = 1'b0;
    repeat (8) tick();
    rd(2'd2, 32'd1, "coll_mode_ec");

    // Collision: ec clear on the press edge leaves ec set.
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd0, "ec_cleared2");
    in_port = 1'b1;
    repeat (6) tick();
    address = 2'd2; writedata = 32'd1; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    check("coll_ec_mode", {29'd0, mode}, 32'd1);
    repeat (2) tick();
    in_port = 1'b0;
    repeat (8) tick();
    rd(2'd2, 32'd1, "coll_ec_kept");
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd0, "ec_clear_plain");

`ifdef ONCHIPALARM_MODE_IRQ_EN
    wr(2'd3, 32'd1);
    rd(2'd3, 32'd1, "msk_set");
    in_port = 1'b1;
    repeat (7) tick();
    check("irq_same_edge_as_ec", {31'd0, irq}, 32'd0);
    tick();
    check("irq_after_ec", {31'd0, irq}, 32'd1);
    repeat (2) tick();
    in_port = 1'b0;
    repeat (8) tick();
    check("irq_held", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'd1);
    tick();
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    do_press(3'd2, "noirq_press");
    check("noirq_irq", {31'd0, irq}, 32'd0);
    wr(2'd3, 32'd1);
    rd(2'd3, 32'd0, "noirq_rd3");
    check("noirq_irq_after_wr", {31'd0, irq}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
